dp_ram_port_ctrl: RTL
=====================

// Module: dp_ram_port_ctrl
// PURPOSE
//  Request/response front-end for one port of the dual-port synchronous RAM.
//  Converts a valid/ready read/write request stream into the RAM's active-low strobes (cs/we/oe).
//  It also captures the registered read data into a held response.
//  Sits directly upstream of one RAM port: two instances serve port 0 and port 1.
//  Keeps saturating read and write transaction counters for bring-up and debug.
// PARAMETERS
//  ADDR_WIDTH  4   RAM address width; must match the RAM instance
//  DATA_WIDTH  16  RAM data width; must match the RAM instance
//  CNT_WIDTH   16  width of the rd_count and wr_count statistics counters
// PORTS
//  clk          in   1           single clock, shared with the RAM
//  reset_n      in   1           asynchronous, active-low reset
//  req_valid    in   1           request present
//  req_ready    out  1           request accepted when req_valid && req_ready at posedge
//  req_we       in   1           1 = write, 0 = read
//  req_addr     in   ADDR_WIDTH  request address
//  req_wdata    in   DATA_WIDTH  write data (ignored for reads)
//  rsp_valid    out  1           read response held valid
//  rsp_ready    in   1           response consumed when rsp_valid && rsp_ready at posedge
//  rsp_rdata    out  DATA_WIDTH  read data
//  ram_cs       out  1           RAM chip select, active low
//  ram_we       out  1           RAM write enable, active low
//  ram_oe       out  1           RAM output enable, active low
//  ram_addr     out  ADDR_WIDTH  RAM address
//  ram_data_in  out  DATA_WIDTH  write data to the RAM
//  ram_data_out in   DATA_WIDTH  registered RAM read data; 0 when the RAM is not reading
//  cnt_clr      in   1           synchronous clear of both counters
//  rd_count     out  CNT_WIDTH   completed reads; saturating
//  wr_count     out  CNT_WIDTH   issued writes; saturating
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async, reset_n=0) forces:
//      state=IDLE; ram_cs=ram_we=ram_oe=1;
//      ram_addr=0; ram_data_in=0;
//      rsp_valid=0; rsp_rdata=0;
//      req_ready=0 while in reset; req_ready=1 from the first clock edge after release;
//      rd_count=wr_count=0.
//  - Reset mid-read: the read is abandoned, no response is produced, strobes deassert immediately.
//  - Strobe encodings:
//      idle  = cs=1, we=1, oe=1
//      write = cs=0, we=0, oe=1
//      read  = cs=0, we=1, oe=0
//  - FSM states are IDLE, WR, RD_STB, RD_WAIT, RESP. req_ready=1 only in IDLE and WR.
//  - IDLE/WR, accept write: next state WR; drive the write strobe with req_addr/req_wdata for exactly one cycle.
//  - IDLE/WR, accept read: next state RD_STB; drive the read strobe with req_addr for one cycle.
//  - IDLE/WR, no accept: next state IDLE; strobes return to idle.
//  - Back-to-back writes sustain one write per cycle. The strobe stays low across consecutive accepted writes.
//  - RD_STB: the RAM latches the read at the next edge. Strobes go idle and the FSM moves to RD_WAIT.
//  - RD_WAIT: ram_data_out is valid. Capture it into rsp_rdata, set rsp_valid=1, and move to RESP.
//  - Read latency: rsp_valid rises 2 cycles after the accepting edge (rises at edge E+2 for acceptance at edge E).
//  - RESP: hold rsp_valid and rsp_rdata stable until rsp_ready. On rsp_ready, clear rsp_valid and return to IDLE.
//  - rsp_valid && rsp_ready in RESP takes one cycle, and req_ready is 0 in RESP.
//    The earliest next acceptance is therefore at the edge after the response handshake.
//  - Only one read is outstanding at a time. No request is accepted from RD_STB through RESP.
//  - Counters:
//      wr_count increments on each write strobe cycle; rd_count increments when leaving RESP.
//      Both saturate at all-ones (no wrap).
//      cnt_clr wins over a simultaneous increment: the counter reads 0 on the next cycle.
//  - Shared RAM: port-0 writes take priority over port-1 writes in the same cycle, and the losing port-1 write is dropped.
//    The system must not issue same-cycle writes on both ports; this block does not detect the collision.
// TESTING
//  1. Assert reset_n=0 mid-read -> strobes are 1/1/1 and rsp_valid=0 at once; after release, req_ready=1 and counters are 0.
//  2. Write addr 3 = 0xBEEF, then read addr 3 -> rsp_valid rises at acceptance edge +2 with rsp_rdata=0xBEEF; wr_count=1, rd_count=1.
//  3. Issue writes to addrs 0..15 on consecutive cycles -> 16 cycles of cs=0, we=0, oe=1; wr_count=16.
//  4. Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_rdata stay stable; req_ready=0 throughout; a request offered meanwhile is accepted only after the handshake.
//  5. Use CNT_WIDTH=2 and perform 5 writes -> wr_count saturates at 3; cnt_clr asserted on a write cycle -> wr_count=0.
//  6. Drive random read/write traffic for 2k transactions against a reference memory model -> every rsp_rdata matches the model, and no strobe pattern other than idle, write or read appears.

Source files
------------

// File: rtl/dp_ram_port_ctrl.sv
// dp_ram_port_ctrl
//
// Request/response front-end for one port of the dual-port synchronous RAM.
// A valid/ready request stream is turned into the RAM's active-low
// cs/we/oe strobes, and the registered read data is captured into a held
// response. Two instances serve the two RAM ports. Port 0 writes win over
// port 1 writes in the same cycle inside the RAM. This block does not
// detect such collisions; the system must avoid them.
//
// Ports
//   clk, reset_n                 clock and asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_we, req_addr, req_wdata  request payload (1 = write, 0 = read)
//   rsp_valid/rsp_ready          read response handshake
//   rsp_rdata                    held read data
//   ram_cs, ram_we, ram_oe       RAM strobes, active low
//   ram_addr, ram_data_in        RAM address and write data
//   ram_data_out                 registered RAM read data
//   cnt_clr                      synchronous clear of both counters
//   rd_count, wr_count           saturating transaction counters
//
// Every output is a register. The combinational process computes the next
// value of each output, and the sequential processes load those values.

module dp_ram_port_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_STB,
    RD_WAIT,
    RESP
  } state_t;

  state_t                state, state_nxt;
  logic                  req_ready_nxt;
  logic                  cs_nxt, we_nxt, oe_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic                  rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
  logic                  accept;
  logic                  wr_inc, rd_inc;

  // req_ready is a register that equals "state is IDLE or WR". The only
  // exception is the cycle straight after reset release, when it is still
  // 0. Using it directly as the accept qualifier keeps the handshake exact.
  assign accept = req_valid && req_ready;

  // Next-state and next-output logic. Strobes default to idle so that any
  // state which does not explicitly start a RAM access leaves the RAM
  // deselected. Address and write data hold their last value.
  always_comb begin
    state_nxt     = state;
    cs_nxt        = 1'b1;
    we_nxt        = 1'b1;
    oe_nxt        = 1'b1;
    addr_nxt      = ram_addr;
    wdata_nxt     = ram_data_in;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    wr_inc        = 1'b0;
    rd_inc        = 1'b0;

    case (state)
      IDLE, WR: begin
        if (accept) begin
          addr_nxt = req_addr;
          cs_nxt   = 1'b0;
          if (req_we) begin
            state_nxt = WR;
            we_nxt    = 1'b0;
            wdata_nxt = req_wdata;
            wr_inc    = 1'b1;
          end else begin
            state_nxt = RD_STB;
            oe_nxt    = 1'b0;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      // The RAM samples the read strobe at the edge that leaves RD_STB.
      RD_STB: begin
        state_nxt = RD_WAIT;
      end
      // The RAM's registered output now holds the addressed word.
      RD_WAIT: begin
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = ram_data_out;
        state_nxt     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          rd_inc        = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    req_ready_nxt = (state_nxt == IDLE) || (state_nxt == WR);
  end

  // State and registered outputs. Reset abandons any read in flight and
  // drops the strobes at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      ram_cs      <= 1'b1;
      ram_we      <= 1'b1;
      ram_oe      <= 1'b1;
      ram_addr    <= '0;
      ram_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state       <= state_nxt;
      req_ready   <= req_ready_nxt;
      ram_cs      <= cs_nxt;
      ram_we      <= we_nxt;
      ram_oe      <= oe_nxt;
      ram_addr    <= addr_nxt;
      ram_data_in <= wdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
    end
  end

  // Saturating statistics counters. A clear overrides an increment in the
  // same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (cnt_clr) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_inc && (wr_count != '1)) begin
        wr_count <= wr_count + CNT_WIDTH'(1);
      end
      if (rd_inc && (rd_count != '1)) begin
        rd_count <= rd_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
